regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two sources: the pipeline writeback stage (requester A, never stalls) and a multi-cycle execution unit (requester B, valid/ready handshake). B results queue in a small FIFO and drain into idle write-port cycles. The block kills queued B results made stale by younger A writes. It exports a pending-register mask for hazard logic and a stall request that guarantees B forward progress. It sits between the WB stage / multi-cycle unit and the register file write port.

---
 rtl/regfile_wb_arbiter_if.sv | 24 ++
 rtl/regfile_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the writeback, multi-cycle result and register-file write-port signals.
// The arbiter takes the slave side; the requester/driver takes the master side.
interface regfile_wb_arbiter_if;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        mc_valid;
   logic [4:0]  mc_reg;
   logic [31:0] mc_data;
   logic        mc_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   modport master (
      output wb_valid, wb_reg, wb_data, mc_valid, mc_reg, mc_data,
      input  mc_ready, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  wb_valid, wb_reg, wb_data, mc_valid, mc_reg, mc_data,
      output mc_ready, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the WB stage (always wins) and a
// queued multi-cycle unit, killing queued results overwritten by younger WB writes.
module regfile_wb_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 8,
   parameter bit ZERO_PROTECT = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   regfile_wb_arbiter_if.slave    bus,
   output logic [31:0]            pend_mask,
   output logic                   stall_req,
   output logic [$clog2(DEPTH):0] fifo_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic [DEPTH-1:0] ent_live;
   logic [4:0]       ent_reg  [DEPTH];
   logic [31:0]      ent_data [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [SW-1:0]    starve_cnt;
   logic [SW-1:0]    starve_next;
   logic             pop_last;
   logic             a_eff;
   logic             push;
   logic             pop;
   logic             new_live;

   assign a_eff        = bus.wb_valid && !(ZERO_PROTECT && (bus.wb_reg == 5'd0));
   assign bus.mc_ready = rst && (fifo_count < FULL);
   assign push         = bus.mc_valid && bus.mc_ready;
   assign pop          = !a_eff && (fifo_count != '0);
   // A same-cycle WB write to the same register already supersedes the incoming result.
   assign new_live     = !(ZERO_PROTECT && (bus.mc_reg == 5'd0)) &&
                         !(a_eff && (bus.mc_reg == bus.wb_reg));

   always_comb begin
      starve_next = starve_cnt;
      if (pop)
         starve_next = '0;
      else if (a_eff && (fifo_count != '0) && (starve_cnt != LIMIT))
         starve_next = starve_cnt + 1'b1;
   end

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++)
         if (ent_live[i])
            pend_mask[ent_reg[i]] = 1'b1;
   end

   // Entry payload needs no reset: a slot only matters once its live bit is set.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_reg[wptr]  <= bus.mc_reg;
         ent_data[wptr] <= bus.mc_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_live   <= '0;
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (a_eff && (ent_reg[i] == bus.wb_reg))
               ent_live[i] <= 1'b0;
         if (pop) begin
            ent_live[rptr] <= 1'b0;
            rptr           <= rptr + 1'b1;
         end
         if (push) begin
            ent_live[wptr] <= new_live;
            wptr           <= wptr + 1'b1;
         end
         if (push && !pop)
            fifo_count <= fifo_count + 1'b1;
         else if (pop && !push)
            fifo_count <= fifo_count - 1'b1;
      end
   end

   // Write port and starvation tracking; a dead head still consumes its pop cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rf_we    <= 1'b0;
         bus.rf_waddr <= '0;
         bus.rf_wdata <= '0;
         starve_cnt   <= '0;
         stall_req    <= 1'b0;
         pop_last     <= 1'b0;
      end else begin
         starve_cnt <= starve_next;
         pop_last   <= pop;
         if (a_eff) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= bus.wb_reg;
            bus.rf_wdata <= bus.wb_data;
         end else if (pop) begin
            bus.rf_we <= ent_live[rptr];
            if (ent_live[rptr]) begin
               bus.rf_waddr <= ent_reg[rptr];
               bus.rf_wdata <= ent_data[rptr];
            end
         end else begin
            bus.rf_we <= 1'b0;
         end
         if ((STARVE_LIMIT > 0) && (starve_next == LIMIT))
            stall_req <= 1'b1;
         else if (pop_last)
            stall_req <= 1'b0;
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based model
// of the arbitration, kill and starvation rules.
module tb_regfile_wb_arbiter;
   localparam int DEPTH = 2;
   localparam int LIMIT = 8;
   localparam bit ZP    = 1'b1;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [31:0]            pend_mask;
   logic                   stall_req;
   logic [$clog2(DEPTH):0] fifo_count;

   regfile_wb_arbiter_if bus();

   regfile_wb_arbiter #(
      .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .ZERO_PROTECT(ZP)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .pend_mask(pend_mask), .stall_req(stall_req), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   typedef struct {
      bit          live;
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   ent_t        m_head;
   bit          m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_starve;
   bit          m_stall;
   bit          m_pop_last;
   bit          m_ae;
   bit          m_acc;
   bit          m_popped;
   int          m_pre;
   logic [31:0] exp_pend;
   logic [31:0] rf_img [32];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: one write-port decision per edge, expressed over a queue of pending results.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_we = 0; m_addr = '0; m_data = '0;
         m_starve = 0; m_stall = 0; m_pop_last = 0;
      end else begin
         m_ae     = bus.wb_valid && !(ZP && bus.wb_reg == 5'd0);
         m_pre    = mq.size();
         m_acc    = bus.mc_valid && (m_pre < DEPTH);
         m_popped = 0;
         if (m_ae) begin
            foreach (mq[i]) if (mq[i].r == bus.wb_reg) mq[i].live = 0;
            m_we = 1; m_addr = bus.wb_reg; m_data = bus.wb_data;
            if (m_pre > 0 && m_starve < LIMIT) m_starve++;
         end else if (m_pre > 0) begin
            m_head = mq.pop_front();
            m_we = m_head.live;
            if (m_head.live) begin m_addr = m_head.r; m_data = m_head.d; end
            m_starve = 0;
            m_popped = 1;
         end else begin
            m_we = 0;
         end
         if (m_acc)
            mq.push_back('{live: !(ZP && bus.mc_reg == 5'd0) && !(m_ae && bus.mc_reg == bus.wb_reg),
                           r: bus.mc_reg, d: bus.mc_data});
         if (LIMIT > 0 && m_starve == LIMIT) m_stall = 1;
         else if (m_pop_last) m_stall = 0;
         m_pop_last = m_popped;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         exp_pend = '0;
         foreach (mq[i]) if (mq[i].live) exp_pend[mq[i].r] = 1'b1;
         checkOutput("rf_we", {31'd0, bus.rf_we}, {31'd0, m_we});
         checkOutput("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, m_addr});
         checkOutput("rf_wdata", bus.rf_wdata, m_data);
         checkOutput("pend_mask", pend_mask, exp_pend);
         checkOutput("stall_req", {31'd0, stall_req}, {31'd0, m_stall});
         checkOutput("fifo_count", 32'(fifo_count), 32'(mq.size()));
         checkOutput("mc_ready", {31'd0, bus.mc_ready}, {31'd0, rst && (mq.size() < DEPTH)});
      end
   end

   // Register-file image written the way the real array would be, from the DUT port.
   always @(negedge clk)
      if (rst && bus.rf_we) rf_img[bus.rf_waddr] <= bus.rf_wdata;

   // Inputs are set at a negedge, sampled at the next posedge; returns at the following negedge.
   task automatic applyStimulus(input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                                input bit mv, input logic [4:0] mr, input logic [31:0] md);
      bus.wb_valid = wv; bus.wb_reg = wr; bus.wb_data = wd;
      bus.mc_valid = mv; bus.mc_reg = mr; bus.mc_data = md;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int       idx;
      bit       acc_now;
      bit       mv;
      logic [4:0]  mr;
      logic [31:0] md;
      int       wprob;

      bus.wb_valid = 0; bus.wb_reg = '0; bus.wb_data = '0;
      bus.mc_valid = 0; bus.mc_reg = '0; bus.mc_data = '0;
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      #2;
      checkOutput("reset rf_we", {31'd0, bus.rf_we}, 32'd0);
      checkOutput("reset fifo_count", 32'(fifo_count), 32'd0);
      checkOutput("reset pend_mask", pend_mask, 32'd0);
      checkOutput("reset mc_ready", {31'd0, bus.mc_ready}, 32'd0);
      checkOutput("reset stall_req", {31'd0, stall_req}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("release mc_ready", {31'd0, bus.mc_ready}, 32'd1);

      $display("[TB] single WB write");
      applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
      checkOutput("wb rf_we", {31'd0, bus.rf_we}, 32'd1);
      checkOutput("wb rf_waddr", {27'd0, bus.rf_waddr}, 32'd5);
      checkOutput("wb rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checkOutput("wb idle rf_we", {31'd0, bus.rf_we}, 32'd0);

      $display("[TB] back-to-back B results with A idle");
      applyStimulus(0, 5'd0, 32'd0, 1, 5'd3, 32'h11);
      checkOutput("b1 fifo_count", 32'(fifo_count), 32'd1);
      checkOutput("b1 pend_mask", pend_mask, 32'h8);
      applyStimulus(0, 5'd0, 32'd0, 1, 5'd4, 32'h22);
      checkOutput("b1 write addr", {27'd0, bus.rf_waddr}, 32'd3);
      checkOutput("b1 write data", bus.rf_wdata, 32'h11);
      checkOutput("b2 fifo_count", 32'(fifo_count), 32'd1);
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checkOutput("b2 write addr", {27'd0, bus.rf_waddr}, 32'd4);
      checkOutput("b2 write data", bus.rf_wdata, 32'h22);
      checkOutput("b drained pend_mask", pend_mask, 32'd0);

      $display("[TB] starvation under continuous WB");
      idx = 0;
      for (int c = 0; c < 9; c++) begin
         acc_now = (idx < 3) && bus.mc_ready;
         applyStimulus(1, 5'd7, 32'h77, idx < 3, 5'(8 + idx), 32'h80 + 32'(idx));
         if (acc_now) idx++;
         if (c == 1) begin
            checkOutput("full fifo_count", 32'(fifo_count), 32'd2);
            checkOutput("full pend_mask", pend_mask, 32'h300);
            checkOutput("full mc_ready", {31'd0, bus.mc_ready}, 32'd0);
         end
         if (c == 7) checkOutput("stall before limit", {31'd0, stall_req}, 32'd0);
         if (c == 8) checkOutput("stall at limit", {31'd0, stall_req}, 32'd1);
      end
      checkOutput("accepts while blocked", 32'(idx), 32'd2);
      applyStimulus(0, 5'd0, 32'd0, 1, 5'd10, 32'h82);
      checkOutput("drain reg8 we", {31'd0, bus.rf_we}, 32'd1);
      checkOutput("drain reg8 addr", {27'd0, bus.rf_waddr}, 32'd8);
      checkOutput("stall held on pop", {31'd0, stall_req}, 32'd1);
      applyStimulus(0, 5'd0, 32'd0, 1, 5'd10, 32'h82);
      checkOutput("stall cleared", {31'd0, stall_req}, 32'd0);
      checkOutput("drain reg9 addr", {27'd0, bus.rf_waddr}, 32'd9);
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checkOutput("drain reg10 addr", {27'd0, bus.rf_waddr}, 32'd10);
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

      $display("[TB] younger WB kills queued result");
      applyStimulus(1, 5'd7, 32'h1, 1, 5'd6, 32'hAA);
      checkOutput("kill pend before", pend_mask & 32'h40, 32'h40);
      applyStimulus(1, 5'd6, 32'hBB, 0, 5'd0, 32'd0);
      checkOutput("kill wb data", bus.rf_wdata, 32'hBB);
      checkOutput("kill pend after", pend_mask & 32'h40, 32'd0);
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checkOutput("dead pop rf_we", {31'd0, bus.rf_we}, 32'd0);
      checkOutput("dead pop fifo_count", 32'(fifo_count), 32'd0);
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checkOutput("reg6 final", rf_img[6], 32'hBB);

      $display("[TB] same-cycle collision and register 0");
      applyStimulus(1, 5'd12, 32'hC0, 1, 5'd12, 32'hC1);
      checkOutput("coll addr", {27'd0, bus.rf_waddr}, 32'd12);
      checkOutput("coll pend12", pend_mask & 32'h1000, 32'd0);
      checkOutput("coll fifo_count", 32'(fifo_count), 32'd1);
      applyStimulus(1, 5'd0, 32'h5, 1, 5'd0, 32'h6);
      checkOutput("coll dead pop we", {31'd0, bus.rf_we}, 32'd0);
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checkOutput("reg0 no write", {31'd0, bus.rf_we}, 32'd0);
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checkOutput("reg0 dead pop", {31'd0, bus.rf_we}, 32'd0);

      $display("[TB] reset mid-drain");
      applyStimulus(1, 5'd7, 32'h9, 1, 5'd20, 32'h2020);
      applyStimulus(1, 5'd7, 32'h9, 1, 5'd21, 32'h2121);
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checkOutput("pre-reset rf_we", {31'd0, bus.rf_we}, 32'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("mid reset rf_we", {31'd0, bus.rf_we}, 32'd0);
      checkOutput("mid reset fifo_count", 32'(fifo_count), 32'd0);
      checkOutput("mid reset pend_mask", pend_mask, 32'd0);
      checkOutput("mid reset mc_ready", {31'd0, bus.mc_ready}, 32'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      checkOutput("post reset mc_ready", {31'd0, bus.mc_ready}, 32'd1);

      $display("[TB] randomized traffic");
      mv = 0; mr = '0; md = '0; acc_now = 1;
      for (int c = 0; c < 3000; c++) begin
         case ((c / 200) % 3)
            0:       wprob = 25;
            1:       wprob = 60;
            default: wprob = 95;
         endcase
         if (!mv || acc_now) begin
            mv = ($urandom_range(0, 1) == 1);
            mr = 5'($urandom_range(0, 15));
            md = $urandom;
         end
         acc_now = mv && bus.mc_ready;
         applyStimulus(($urandom_range(0, 99) < wprob), 5'($urandom_range(0, 15)), $urandom, mv, mr, md);
         if (c == 1500) begin
            #2 rst = 1'b0;
            @(negedge clk);
            #2 rst = 1'b1;
            @(negedge clk);
            acc_now = 1;
         end
      end
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
